// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and types for the AES round sequencer.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  // Round index width: covers round 0..14.
  localparam int RK_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/aes_round_seq.sv
// aes_round_seq: iterative AES round sequencer.
// Loads one block with the round-0 AddRoundKey, steps an external single-round
// datapath NR times (MixColumns bypassed on the last round), then holds the
// result on a valid/ready output. A DONE-state handshake may load the next
// block in the same cycle so blocks stream at one per NR+1 cycles.
// Optional build macro: AES_SEQ_ABORT_EN adds an abort input that drops the
// block in flight and scrubs the state register.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int NR      = NR_AES128,
  parameter bit ENC_DEC = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic [RK_IDX_W-1:0]    rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk_data,
  output logic [AES_BLOCK_W-1:0] dp_state,
  output logic                   dp_final,
  output logic                   dp_dec,
  input  logic [AES_BLOCK_W-1:0] dp_result,
`ifdef AES_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   busy
);

  localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NR);

  seq_state_e             fsm_q, fsm_d;
  logic [RK_IDX_W-1:0]    round_q, round_d;
  logic [AES_BLOCK_W-1:0] state_reg_q, state_reg_d;
  logic                   in_ready_c;
  logic                   abort_c;

`ifdef AES_SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Next-state, round counter, state register and handshake outputs.
  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_reg_d = state_reg_q;
    in_ready_c  = 1'b0;
    out_valid   = 1'b0;
    rk_idx      = '0;
    dp_final    = 1'b0;
    busy        = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          state_reg_d = in_data ^ rk_data;
          round_d     = RK_IDX_W'(1);
          fsm_d       = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        rk_idx      = round_q;
        dp_final    = (round_q == LAST_RND);
        state_reg_d = dp_result;
        if (round_q == LAST_RND) fsm_d = DONE;
        else                     round_d = round_q + 1'b1;
      end
      DONE: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        // rk_idx stays 0 here so a back-to-back load sees the round-0 key.
        in_ready_c = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_reg_d = in_data ^ rk_data;
            round_d     = RK_IDX_W'(1);
            fsm_d       = RUN;
          end else begin
            round_d = '0;
            fsm_d   = IDLE;
          end
        end
      end
      default: begin
        round_d = '0;
        fsm_d   = IDLE;
      end
    endcase
    // Abort wins over completion and over a same-cycle load; key-derived
    // state is scrubbed so nothing lingers in the register.
    if (abort_c && (fsm_q != IDLE)) begin
      fsm_d       = IDLE;
      round_d     = '0;
      state_reg_d = '0;
      in_ready_c  = 1'b0;
    end
  end

  // FSM, round counter and state register flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= IDLE;
      round_q     <= '0;
      state_reg_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_reg_q <= state_reg_d;
    end
  end

  assign in_ready = in_ready_c & reset_n;
  assign out_data = state_reg_q;
  assign dp_state = state_reg_q;
  assign dp_dec   = ENC_DEC;

endmodule
